// File: rtl/packet_drain_controller.sv
// rtl/packet_drain_controller.sv - drains completed reassembly-buffer packets flit by flit to one consumer
package types;
    typedef struct packed {
        logic [1:0]  flit_type;
        logic [29:0] payload;
    } flit_t;
endpackage

package packet_types;
    localparam int BUFFER_FLITS = 8;
    localparam int TAIL_W       = 4;

    typedef struct packed {
        logic [TAIL_W-1:0]                 tail_index;
        types::flit_t [BUFFER_FLITS-1:0]   buffer;
    } packet_element_t;
endpackage

module packet_drain_controller #(
    parameter int MAX_PACKET_FLITS = 8,
    parameter int DRAIN_TIMEOUT    = 256,
    parameter int DROP_CNT_WIDTH   = 16
) (
    input  logic                            nocclk,
    input  logic                            rst_n,
    input  packet_types::packet_element_t   transfered_packet,
    input  logic                            transfered_packet_valid,
    output logic                            transfered_packet_completed,
    output types::flit_t                    out_flit,
    output logic                            out_flit_valid,
    input  logic                            out_flit_ready,
    output logic                            busy,
    output logic [DROP_CNT_WIDTH-1:0]       dropped_count
);

    localparam int IDX_W   = $clog2(MAX_PACKET_FLITS + 1);
    localparam int RD_W    = $clog2(packet_types::BUFFER_FLITS);
    localparam int STALL_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int TAIL_W  = packet_types::TAIL_W;

    localparam logic [TAIL_W-1:0]  MAX_TAIL    = TAIL_W'(MAX_PACKET_FLITS);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        DONE      = 2'd2,
        DONE_DROP = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          total_q, total_d;
    logic [STALL_W-1:0]        stall_q, stall_d;
    types::flit_t              flit_q, flit_d;
    logic                      valid_q, valid_d;
    logic                      completed_q, completed_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

    logic [TAIL_W-1:0]         tail;
    logic                      malformed;
    logic                      handshake;
    logic [RD_W-1:0]           rd_sel;

    assign tail      = transfered_packet.tail_index;
    assign malformed = (tail == '0) || (tail > MAX_TAIL);
    assign handshake = valid_q & out_flit_ready;
    assign rd_sel    = RD_W'(idx_q);

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            total_q     <= '0;
            stall_q     <= '0;
            flit_q      <= '0;
            valid_q     <= 1'b0;
            completed_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            total_q     <= total_d;
            stall_q     <= stall_d;
            flit_q      <= flit_d;
            valid_q     <= valid_d;
            completed_q <= completed_d;
            drop_q      <= drop_d;
        end
    end

    // completed_d is asserted on every transition into DONE/DONE_DROP so the
    // strobe is a flop that tracks exactly those two states.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        total_d     = total_q;
        stall_d     = stall_q;
        flit_d      = flit_q;
        valid_d     = valid_q;
        completed_d = 1'b0;
        drop_d      = drop_q;

        case (state_q)
            IDLE: begin
                if (transfered_packet_valid) begin
                    total_d = IDX_W'(tail);
                    if (malformed) begin
                        state_d     = DONE_DROP;
                        completed_d = 1'b1;
                    end else begin
                        flit_d  = transfered_packet.buffer[0];
                        valid_d = 1'b1;
                        idx_d   = IDX_W'(1);
                        stall_d = '0;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                // A handshake in the timeout cycle takes priority over the abort.
                if (handshake) begin
                    stall_d = '0;
                    if (idx_q == total_q) begin
                        valid_d     = 1'b0;
                        state_d     = DONE;
                        completed_d = 1'b1;
                    end else begin
                        flit_d = transfered_packet.buffer[rd_sel];
                        idx_d  = idx_q + 1'b1;
                    end
                end else if (stall_q == STALL_LIMIT) begin
                    valid_d     = 1'b0;
                    stall_d     = '0;
                    state_d     = DONE_DROP;
                    completed_d = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            DONE_DROP: begin
                idx_d   = '0;
                state_d = IDLE;
                if (drop_q != '1) begin
                    drop_d = drop_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign transfered_packet_completed = completed_q;
    assign out_flit                    = flit_q;
    assign out_flit_valid              = valid_q;
    assign busy                        = (state_q != IDLE);
    assign dropped_count               = drop_q;

    // The buffer must keep the head entry presented until it sees completion.
    property p_head_held;
        @(posedge nocclk) disable iff (!rst_n)
            (state_q != IDLE) |-> transfered_packet_valid;
    endproperty
    a_head_held: assert property (p_head_held);

endmodule
